stage_move_gate: RTL and testbench

STAGE_MOVE_GATE -- requirements
Module: stage_move_gate

---
 rtl/stage_move_gate_if.sv | 34 +++
 rtl/stage_move_gate.sv | 160 ++++++++++++++++
 tb/tb_stage_move_gate.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_move_gate_if.sv
// stage_move_gate_if
//   Groups the chef position/key inputs and the move-permission outputs of
//   stage_move_gate. The clock and reset are kept outside the interface.
//   master : environment side (drives Stage/keycode/position, observes outputs)
//   slave  : stage_move_gate side
//   Signals:
//     Stage[2:0]       current stage number
//     keycode[7:0]     held key (0x04 left, 0x07 right, 0x16 down, 0x1A up)
//     Chef_X_Pos[9:0]  chef column, unsigned
//     Chef_Y_Pos[9:0]  chef row, unsigned
//     valid            registered move permission
//     dir[1:0]         registered direction (00 L, 01 R, 10 D, 11 U)
//     step             one-cycle movement step pulse
//     mstate[1:0]      FSM state (00 IDLE, 01 WALK, 10 CLIMB)
interface stage_move_gate_if;
  logic [2:0] Stage;
  logic [7:0] keycode;
  logic [9:0] Chef_X_Pos;
  logic [9:0] Chef_Y_Pos;
  logic       valid;
  logic [1:0] dir;
  logic       step;
  logic [1:0] mstate;

  modport master (
    output Stage, keycode, Chef_X_Pos, Chef_Y_Pos,
    input  valid, dir, step, mstate
  );

  modport slave (
    input  Stage, keycode, Chef_X_Pos, Chef_Y_Pos,
    output valid, dir, step, mstate
  );
endinterface

// File: rtl/stage_move_gate.sv
// stage_move_gate
//   Decides whether the chef may move in the direction of the held key,
//   based on floor rows / ladder columns and the play-field limits, and
//   paces the movement with a periodic step pulse.
//   Ports:
//     frame_clk  sole clock, rising edge
//     Reset      synchronous, active-high
//     bus        stage_move_gate_if.slave (Stage, keycode, Chef_X/Y_Pos in;
//                valid, dir, step, mstate out)
//   Optional feature: define STAGE_BLANK_EN to blank movement for
//   BLANK_FRAMES cycles after every change of Stage.
//
//   state | meaning
//   IDLE  | no legal key held, valid=0, dir holds
//   WALK  | legal left/right held, moving along a floor
//   CLIMB | legal up/down held, moving along a ladder
module stage_move_gate #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 192,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 141,
  parameter int NUM_FLOORS   = 4,
  parameter int FLOOR_Y0     = 21,
  parameter int FLOOR_PITCH  = 40,
  parameter int NUM_LADDERS  = 5,
  parameter int LADDER_X0    = 16,
  parameter int LADDER_PITCH = 40,
  parameter int STEP_DIV     = 2,
  parameter int NUM_STAGES   = 4,
  parameter int BLANK_FRAMES = 8
) (
  input logic              frame_clk,
  input logic              Reset,
  stage_move_gate_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WALK  = 2'b01;
  localparam logic [1:0] ST_CLIMB = 2'b10;

  localparam logic [1:0] DIR_L = 2'b00;
  localparam logic [1:0] DIR_R = 2'b01;
  localparam logic [1:0] DIR_D = 2'b10;
  localparam logic [1:0] DIR_U = 2'b11;

  localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);

  if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_bad_step_div
    $error("STEP_DIV must be in 1..255");
  end
  if (BLANK_FRAMES < 1 || BLANK_FRAMES > 255) begin : g_bad_blank
    $error("BLANK_FRAMES must be in 1..255");
  end

  logic [1:0] state_q, state_d;
  logic [1:0] dir_q, dir_d;
  logic       valid_q, valid_d;
  logic [7:0] cnt_q, cnt_d;

  logic on_floor, on_ladder, stage_ok, blank_force;
  logic mv_l, mv_r, mv_d, mv_u;

  always_comb begin
    on_floor = 1'b0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (bus.Chef_Y_Pos == 10'(FLOOR_Y0 + k * FLOOR_PITCH)) on_floor = 1'b1;
    end
  end

  always_comb begin
    on_ladder = 1'b0;
    for (int j = 0; j < NUM_LADDERS; j++) begin
      if (bus.Chef_X_Pos == 10'(LADDER_X0 + j * LADDER_PITCH)) on_ladder = 1'b1;
    end
  end

`ifdef STAGE_BLANK_EN
  logic [2:0] stage_prev_q;
  logic [7:0] blank_q;
  logic       stage_chg;

  assign stage_chg   = (bus.Stage != stage_prev_q);
  // The change cycle itself forces IDLE; the counter covers the remaining
  // BLANK_FRAMES-1 cycles.
  assign blank_force = stage_chg || (blank_q != 8'd0);

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      stage_prev_q <= 3'd0;
      blank_q      <= 8'd0;
    end else begin
      stage_prev_q <= bus.Stage;
      if (stage_chg)            blank_q <= 8'(BLANK_FRAMES - 1);
      else if (blank_q != 8'd0) blank_q <= blank_q - 8'd1;
    end
  end
`else
  assign blank_force = 1'b0;
`endif

  assign stage_ok = (32'(bus.Stage) < NUM_STAGES) && !blank_force;

  assign mv_l = stage_ok && (bus.keycode == 8'h04) && on_floor
                && (bus.Chef_X_Pos > 10'(X_MIN));
  assign mv_r = stage_ok && (bus.keycode == 8'h07) && on_floor
                && (bus.Chef_X_Pos < 10'(X_MAX));
  assign mv_d = stage_ok && (bus.keycode == 8'h16) && on_ladder
                && (bus.Chef_Y_Pos < 10'(Y_MAX));
  assign mv_u = stage_ok && (bus.keycode == 8'h1A) && on_ladder
                && (bus.Chef_Y_Pos > 10'(Y_MIN));

  // At most one key is held, so the next state follows directly from it.
  always_comb begin
    state_d = ST_IDLE;
    dir_d   = dir_q;
    if (mv_l) begin
      state_d = ST_WALK;
      dir_d   = DIR_L;
    end else if (mv_r) begin
      state_d = ST_WALK;
      dir_d   = DIR_R;
    end else if (mv_d) begin
      state_d = ST_CLIMB;
      dir_d   = DIR_D;
    end else if (mv_u) begin
      state_d = ST_CLIMB;
      dir_d   = DIR_U;
    end
  end

  assign valid_d = (state_d != ST_IDLE);

  // Counter restarts whenever a new movement segment begins, so the first
  // step of each segment lands STEP_DIV cycles after it starts.
  always_comb begin
    if (!valid_d || (state_q == ST_IDLE) || (dir_d != dir_q)) cnt_d = 8'd0;
    else if (cnt_q == STEP_LAST)                               cnt_d = 8'd0;
    else                                                       cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_L;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid  = valid_q;
  assign bus.dir    = dir_q;
  assign bus.mstate = state_q;
  assign bus.step   = valid_q && (cnt_q == STEP_LAST);

endmodule

// File: tb/tb_stage_move_gate.sv
module tb_stage_move_gate;
  localparam int X_MIN = 0, X_MAX = 192, Y_MIN = 0, Y_MAX = 141;
  localparam int NUM_FLOORS = 4, FLOOR_Y0 = 21, FLOOR_PITCH = 40;
  localparam int NUM_LADDERS = 5, LADDER_X0 = 16, LADDER_PITCH = 40;
  localparam int STEP_DIV = 2, NUM_STAGES = 4, BLANK_FRAMES = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage_move_gate_if bus ();

  stage_move_gate dut (
    .frame_clk(clk),
    .Reset    (rst),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model state
  bit   exp_valid = 1'b0;
  logic [1:0] exp_dir = 2'b00;
  logic [1:0] exp_mstate = 2'b00;
  bit   exp_step = 1'b0;
  int   run_len = 0;
  int   edge_no = 0;
  int   last_chg = -1000;
  int   prev_stage = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_floor(input int y);
    return (y >= FLOOR_Y0) && ((y - FLOOR_Y0) % FLOOR_PITCH == 0)
           && ((y - FLOOR_Y0) / FLOOR_PITCH < NUM_FLOORS);
  endfunction

  function automatic bit is_ladder(input int x);
    return (x >= LADDER_X0) && ((x - LADDER_X0) % LADDER_PITCH == 0)
           && ((x - LADDER_X0) / LADDER_PITCH < NUM_LADDERS);
  endfunction

  // Model: from the inputs present at an edge, work out what the outputs must
  // show during the following cycle.
  always @(posedge clk) begin
    int x, y, st, want;
    bit ok, blanked;
    x = int'(bus.Chef_X_Pos);
    y = int'(bus.Chef_Y_Pos);
    st = int'(bus.Stage);
    if (rst) begin
      exp_valid = 0; exp_dir = 2'b00; exp_mstate = 2'b00; run_len = 0;
      prev_stage = 0; last_chg = -1000;
    end else begin
      blanked = 1'b0;
`ifdef STAGE_BLANK_EN
      if (st != prev_stage) last_chg = edge_no;
      prev_stage = st;
      blanked = (edge_no - last_chg) < BLANK_FRAMES;
`endif
      want = -1;
      case (bus.keycode)
        8'h04: want = 0;
        8'h07: want = 1;
        8'h16: want = 2;
        8'h1A: want = 3;
        default: want = -1;
      endcase
      ok = 1'b0;
      if (want == 0) ok = is_floor(y) && x > X_MIN;
      if (want == 1) ok = is_floor(y) && x < X_MAX;
      if (want == 2) ok = is_ladder(x) && y < Y_MAX;
      if (want == 3) ok = is_ladder(x) && y > Y_MIN;
      if (st >= NUM_STAGES || blanked) ok = 1'b0;
      if (ok) begin
        if (exp_valid && int'(exp_dir) == want) run_len++;
        else run_len = 1;
        exp_dir = 2'(want);
        exp_mstate = (want < 2) ? 2'b01 : 2'b10;
        exp_valid = 1;
      end else begin
        exp_valid = 0; exp_mstate = 2'b00; run_len = 0;
      end
    end
    exp_step = exp_valid && (run_len % STEP_DIV == 0);
    edge_no++;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("valid", 32'(bus.valid), 32'(exp_valid));
      chk("dir", 32'(bus.dir), 32'(exp_dir));
      chk("mstate", 32'(bus.mstate), 32'(exp_mstate));
      chk("step", 32'(bus.step), 32'(exp_step));
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_in(input int x, input int y, input logic [7:0] k);
    bus.Chef_X_Pos = 10'(x);
    bus.Chef_Y_Pos = 10'(y);
    bus.keycode = k;
  endtask

  function automatic int pick_x();
    int j;
    j = int'($urandom_range(0, NUM_LADDERS - 1));
    case ($urandom_range(0, 6))
      0, 1: return LADDER_X0 + j * LADDER_PITCH;
      2: return LADDER_X0 + j * LADDER_PITCH + 1;
      3: return X_MIN;
      4: return X_MAX;
      5: return X_MAX - 1;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  function automatic int pick_y();
    int k;
    k = int'($urandom_range(0, NUM_FLOORS - 1));
    case ($urandom_range(0, 5))
      0, 1, 2: return FLOOR_Y0 + k * FLOOR_PITCH;
      3: return FLOOR_Y0 + k * FLOOR_PITCH - 1;
      4: return Y_MIN;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  function automatic logic [7:0] pick_key();
    case ($urandom_range(0, 5))
      0: return 8'h04;
      1: return 8'h07;
      2: return 8'h16;
      3: return 8'h1A;
      4: return 8'h00;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bit step_pat [6];
    int hold;
    step_pat[0] = 0; step_pat[1] = 1; step_pat[2] = 0;
    step_pat[3] = 1; step_pat[4] = 0; step_pat[5] = 1;

    bus.Stage = 3'd0;
    set_in(100, 21, 8'h00);
    rst = 1'b1;
    cyc(2);
    check_en = 1'b1;
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_mstate", 32'(bus.mstate), 32'd0);
    chk("reset_dir", 32'(bus.dir), 32'd0);
    chk("reset_step", 32'(bus.step), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Walk right from the middle of floor 0
    set_in(100, 21, 8'h07);
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk("walk_valid", 32'(bus.valid), 32'd1);
      chk("walk_dir", 32'(bus.dir), 32'd1);
      chk("walk_mstate", 32'(bus.mstate), 32'd1);
      chk("walk_step", 32'(bus.step), 32'(step_pat[c]));
    end

    // Reverse direction: dir follows next cycle, step restarts
    set_in(100, 21, 8'h04);
    cyc();
    chk("rev_dir", 32'(bus.dir), 32'd0);
    chk("rev_step0", 32'(bus.step), 32'd0);
    cyc();
    chk("rev_step1", 32'(bus.step), 32'd1);

    // Right boundary
    set_in(192, 21, 8'h07);
    cyc();
    chk("xmax_valid", 32'(bus.valid), 32'd0);
    chk("xmax_mstate", 32'(bus.mstate), 32'd0);
    chk("xmax_dir_hold", 32'(bus.dir), 32'd0);
    set_in(191, 21, 8'h07);
    cyc();
    chk("x191_valid", 32'(bus.valid), 32'd1);

    // Left boundary
    set_in(0, 61, 8'h04);
    cyc();
    chk("xmin_valid", 32'(bus.valid), 32'd0);

    // Ladder column climb, then off-column
    set_in(56, 61, 8'h1A);
    cyc();
    chk("climb_mstate", 32'(bus.mstate), 32'd2);
    chk("climb_dir", 32'(bus.dir), 32'd3);
    set_in(57, 61, 8'h1A);
    cyc();
    chk("offladder_valid", 32'(bus.valid), 32'd0);
    chk("offladder_mstate", 32'(bus.mstate), 32'd0);

    // Bottom boundary on a ladder
    set_in(16, 141, 8'h16);
    cyc();
    chk("ymax_valid", 32'(bus.valid), 32'd0);

    // Illegal stage
    bus.Stage = 3'd5;
    set_in(100, 21, 8'h04);
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk("badstage_valid", 32'(bus.valid), 32'd0);
    end
    bus.Stage = 3'd0;
    set_in(100, 21, 8'h00);
    cyc(BLANK_FRAMES + 2);

`ifdef STAGE_BLANK_EN
    set_in(100, 21, 8'h07);
    cyc(3);
    chk("preblank_valid", 32'(bus.valid), 32'd1);
    bus.Stage = 3'd1;
    for (int c = 0; c < BLANK_FRAMES; c++) begin
      cyc();
      chk("blank_valid", 32'(bus.valid), 32'd0);
      chk("blank_step", 32'(bus.step), 32'd0);
    end
    cyc();
    chk("postblank_valid", 32'(bus.valid), 32'd1);
`endif

    // Reset in the middle of a walk
    set_in(100, 21, 8'h07);
    cyc(3);
    rst = 1'b1;
    cyc();
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_mstate", 32'(bus.mstate), 32'd0);
    chk("midrst_dir", 32'(bus.dir), 32'd0);
    chk("midrst_step", 32'(bus.step), 32'd0);
    rst = 1'b0;

    // Randomized traffic checked by the model on every cycle
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        set_in(pick_x(), pick_y(), bus.keycode);
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 3) == 0) bus.keycode = pick_key();
      if ($urandom_range(0, 60) == 0)
        bus.Stage = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7))
                                                : 3'($urandom_range(0, 3));
      rst = ($urandom_range(0, 250) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
